adsr_envelope_gen: RTL

//  Per-voice ADSR envelope generator; sits directly upstream of the DDFS core and drives its env_ext input.

---
 rtl/adsr_envelope_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adsr_envelope_gen.sv
// adsr_envelope_gen: per-voice ADSR envelope driving the oscillator env_ext, stepped on clken.
// Define ADSR_EXP_EN for exponential decay/release; attack is always linear.
module adsr_envelope_gen #(
  parameter int DW = 16,
  parameter int RW = 24,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clken,
  input  logic          gate_ext,
  input  logic          cs,
  input  logic          sw_read,
  input  logic          sw_write,
  input  logic [4:0]    sw_addr,
  input  logic [PW-1:0] wr_data,
  output logic [PW-1:0] rd_data,
  output logic [DW-1:0] env_out,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;
  localparam logic [RW-1:0] PEAK    = RW'(1) << (RW-2);
  localparam logic [DW-1:0] SUS_RST = DW'(1) << (DW-2);
  state_t        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d, att_q, dec_q, rel_q;
  logic [RW-1:0] sus_raw, sus_full, dec_step, rel_step;
  logic [DW-1:0] sus_q;
  logic [RW:0]   att_sum;
  logic          soft_gate_q, gate_sel_q, gate_q, done_q, done_d;
  logic          gate, rise, fall, att_exit, dec_exit, rel_exit;
  logic          unused;
  assign gate     = gate_sel_q ? soft_gate_q : gate_ext;
  assign rise     = clken & gate & ~gate_q;
  assign fall     = clken & ~gate & gate_q;
  assign sus_raw  = {sus_q, {(RW-DW){1'b0}}};
  assign sus_full = sus_raw > PEAK ? PEAK : sus_raw;
  // One extra bit so a large attack rate near PEAK cannot wrap.
  assign att_sum  = {1'b0, acc_q} + {1'b0, att_q};
  assign att_exit = att_q == '0 || att_sum >= {1'b0, PEAK};
`ifdef ADSR_EXP_EN
  logic [RW-1:0] dec_diff;
  logic [RW:0]   dec_w, rel_w;
  assign dec_diff = acc_q > sus_full ? acc_q - sus_full : '0;
  assign dec_w    = {1'b0, dec_diff >> dec_q[4:0]} + (RW+1)'(1);
  assign dec_exit = dec_w >= {1'b0, dec_diff};
  assign dec_step = dec_w[RW-1:0];
  assign rel_w    = {1'b0, acc_q >> rel_q[4:0]} + (RW+1)'(1);
  assign rel_exit = rel_w >= {1'b0, acc_q};
  assign rel_step = rel_w[RW-1:0];
  assign unused   = ^{sw_read, sw_addr[4:3], wr_data, dec_q, rel_q};
`else
  assign dec_exit = dec_q == '0 || {1'b0, acc_q} <= {1'b0, sus_full} + {1'b0, dec_q};
  assign dec_step = dec_q;
  assign rel_exit = rel_q == '0 || acc_q <= rel_q;
  assign rel_step = rel_q;
  assign unused   = ^{sw_read, sw_addr[4:3], wr_data};
`endif
  always_comb begin
    acc_d   = acc_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (clken) begin
      if (rise) state_d = ATTACK;
      else if (fall && state_q inside {ATTACK, DECAY, SUSTAIN}) state_d = RELEASE;
      else
        case (state_q)
          ATTACK: begin
            acc_d   = att_exit ? PEAK : att_sum[RW-1:0];
            state_d = att_exit ? DECAY : ATTACK;
          end
          DECAY: begin
            acc_d   = dec_exit ? sus_full : acc_q - dec_step;
            state_d = dec_exit ? SUSTAIN : DECAY;
          end
          SUSTAIN: acc_d = sus_full;
          RELEASE: begin
            acc_d   = rel_exit ? '0 : acc_q - rel_step;
            state_d = rel_exit ? IDLE : RELEASE;
            done_d  = rel_exit;
          end
          default: begin
            acc_d   = '0;
            state_d = IDLE;
          end
        endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      state_q     <= IDLE;
      gate_q      <= 1'b0;
      done_q      <= 1'b0;
      att_q       <= '0;
      dec_q       <= '0;
      rel_q       <= '0;
      sus_q       <= SUS_RST;
      soft_gate_q <= 1'b0;
      gate_sel_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      state_q <= state_d;
      done_q  <= done_d;
      if (clken) gate_q <= gate;
      if (cs && sw_write)
        case (sw_addr[2:0])
          3'd0: att_q <= wr_data[RW-1:0];
          3'd1: dec_q <= wr_data[RW-1:0];
          3'd2: sus_q <= wr_data[DW-1:0];
          3'd3: rel_q <= wr_data[RW-1:0];
          3'd4: begin
            soft_gate_q <= wr_data[0];
            gate_sel_q  <= wr_data[1];
          end
          default: ;
        endcase
    end
  end
  assign env_out = acc_q[RW-1:RW-DW];
  assign rd_data = PW'({state_q, env_out});
  assign busy    = state_q != IDLE;
  assign done    = done_q;
endmodule
